prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_byte_assembler.sv | 38 +++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// State encoding plus byte/lane geometry used by loader and assembler.
package prog_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs accepted bytes into a word, little-endian (first byte -> bits 7:0).
// Ports: clk, rst, clear (restart lane 0), load (byte accepted), byte_in,
//        last (current byte completes the word), word_next (word incl. byte_in).
module byte_assembler
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              last,
    output logic [WIDTH-1:0]  word_next
);

    logic [LANE_W-1:0] lane;
    logic [WIDTH-1:0]  word;

    // Shifting in from the top leaves the first byte in lane 0 once full.
    assign word_next = {byte_in, word[WIDTH-1:BYTE_W]};
    assign last      = (lane == LAST_LANE);

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
        end else if (load) begin
            lane <= lane + 1'b1;
            word <= word_next;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: byte stream -> program memory writes, then
// checksum check and CPU reset release.
// Ports: clk, rst, start, byte_in/byte_valid/byte_ready (byte stream),
//        mem_wen/mem_add/mem_wdata (memory write port), cpu_rst, done, err.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_add,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 err
);

    // One extra bit so a full-depth load (N=0 -> DEPTH) needs no wrap.
    localparam logic [ADD_WIDTH:0] FULL = (ADD_WIDTH+1)'(DEPTH);

    state_t state, next;

    logic [ADD_WIDTH:0] n;
    logic [ADD_WIDTH:0] idx;
    logic [BYTE_W-1:0]  csum;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   word_next;
    logic               asm_clear;
    logic               asm_load;
    logic               word_done;

    assign accept    = byte_valid && byte_ready;
    assign asm_clear = (state == S_COUNT) && accept;
    assign asm_load  = (state == S_DATA) && accept;
    assign word_done = asm_load && last;

    byte_assembler #(
        .WIDTH(WIDTH)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (asm_clear),
        .load     (asm_load),
        .byte_in  (byte_in),
        .last     (last),
        .word_next(word_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next       = state;
        byte_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) next = S_COUNT;
            end
            S_COUNT: begin
                byte_ready = 1'b1;
                if (accept) next = S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (accept && last) next = S_WRITE;
            end
            S_WRITE: begin
                next = (idx == n - 1'b1) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                if (accept) next = (byte_in == csum) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                if (start) next = S_COUNT;
            end
            S_ERROR: begin
                if (start) next = S_COUNT;
            end
            default: next = S_IDLE;
        endcase
    end

    // Memory port and status flags are registered off the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            n         <= '0;
            idx       <= '0;
            csum      <= '0;
            mem_wen   <= 1'b0;
            mem_add   <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wen <= word_done;
            if (word_done) begin
                mem_add   <= idx[ADD_WIDTH-1:0];
                mem_wdata <= word_next;
            end
            if (asm_clear) begin
                n    <= (byte_in == '0) ? FULL : (ADD_WIDTH+1)'(byte_in);
                idx  <= '0;
                csum <= byte_in;
            end
            if (asm_load) csum <= csum ^ byte_in;
            if (state == S_WRITE) idx <= idx + 1'b1;
            cpu_rst <= (next != S_RUN);
            done    <= (next == S_RUN);
            err     <= (next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory
// writes plus status checks after each load.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_wen;
    logic [7:0]  mem_add;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    logic [39:0] sb[$];
    logic [31:0] prog[256];

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_wen   (mem_wen),
        .mem_add   (mem_add),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            logic [39:0] e;
            wr_cnt++;
            if (sb.size() == 0) begin
                check("wr_unexp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_add", 64'(mem_add), 64'(e[39:32]));
                check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit is_last,
                        input bit junk);
        int t = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            check("rdy_timeout", 0, 1);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
        if (is_last) begin
            @(negedge clk);
            check("wen_latency", 64'(mem_wen), 1);
            if (junk) begin
                check("rdy_in_write", 64'(byte_ready), 0);
                byte_in    = 8'hAA;
                byte_valid = 1'b1;
                @(posedge clk);
                #1 byte_valid = 1'b0;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] nb, input bit use_ck,
                            input logic [7:0] ck_val, input bit poke,
                            input bit junk, input bit exp_ok);
        logic [7:0]  ck;
        logic [31:0] w;
        int nw;
        nw = (nb == 8'h00) ? 256 : int'(nb);
        pulse_start();
        @(negedge clk);
        check("cpu_rst_on_start", 64'(cpu_rst), 1);
        check("done_on_start", 64'(done), 0);
        send(nb, 1'b0, 1'b0);
        ck = nb;
        if (poke) pulse_start();
        for (int i = 0; i < nw; i++) begin
            w = prog[i];
            sb.push_back({8'(i), w});
            for (int l = 0; l < 4; l++) begin
                send(w[8*l +: 8], l == 3, junk && i == 0);
                ck = ck ^ w[8*l +: 8];
            end
        end
        send(use_ck ? ck_val : ck, 1'b0, 1'b0);
        @(negedge clk);
        check("done", 64'(done), 64'(exp_ok));
        check("err", 64'(err), 64'(!exp_ok));
        check("cpu_rst", 64'(cpu_rst), 64'(!exp_ok));
        check("sb_drained", 64'(sb.size()), 0);
    endtask

    initial begin
        int w0;
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(byte_ready), 0);
        check("rst_wen", 64'(mem_wen), 0);
        check("rst_add", 64'(mem_add), 0);
        check("rst_wdata", 64'(mem_wdata), 0);
        check("rst_cpu_rst", 64'(cpu_rst), 1);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        rst = 1'b0;

        prog[0] = 32'h00100013;
        run_load(8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);

        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        run_load(8'h02, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

        prog[0] = 32'h00100013;
        run_load(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_load(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        w0 = wr_cnt;
        run_load(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("full_wr_count", 64'(wr_cnt - w0), 256);
        check("full_last_add", 64'(mem_add), 64'hFF);

        w0 = wr_cnt;
        pulse_start();
        send(8'h01, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_ready", 64'(byte_ready), 0);
        check("midrst_cpu_rst", 64'(cpu_rst), 1);
        check("midrst_done", 64'(done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_wr", 64'(wr_cnt - w0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
